// File: rtl/write_bmp_stream.sv
// write_bmp_stream: captures one frame of RGB pixel pairs and streams it out as a 24-bit BMP file.
// Define WRITE_BMP_BOTTOM_UP_EN for bottom-up row order (+H height); otherwise top-down (-H height).
module write_bmp_stream #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       horizontal_Pulse,
  input  logic [7:0] data_R_Even,
  input  logic [7:0] data_G_Even,
  input  logic [7:0] data_B_Even,
  input  logic [7:0] data_R_Odd,
  input  logic [7:0] data_G_Odd,
  input  logic [7:0] data_B_Odd,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       done_Flag
);
  localparam int W = IMAGE_WIDTH;
  localparam int H = IMAGE_HEIGHT;
  localparam int PAD = (4 - (3 * W) % 4) % 4;
  localparam int LASTPAD = PAD == 0 ? 0 : PAD - 1;
  localparam int ROWB = 3 * W + PAD;
  localparam logic [31:0] IMG = 32'(ROWB * H);
  localparam logic [31:0] FSIZE = 32'(54 + ROWB * H);
`ifdef WRITE_BMP_BOTTOM_UP_EN
  localparam bit DOWN = 1'b1;
`else
  localparam bit DOWN = 1'b0;
`endif
  localparam logic [31:0] HT = DOWN ? 32'(H) : 32'(-H);
  localparam int RSTART = DOWN ? H - 1 : 0;
  localparam int RLAST = DOWN ? 0 : H - 1;
  // Byte 0 sits in the low byte, so each 32-bit field lands little-endian.
  localparam logic [431:0] HDR = {64'h0, 32'd2835, 32'd2835, IMG, 32'h0, 16'd24, 16'd1,
                                  HT, 32'(W), 32'd40, 32'd54, 32'h0, FSIZE, 8'h4D, 8'h42};
  localparam int D = W * H / 2;
  localparam int AW = D > 1 ? $clog2(D) : 1;
  localparam int CW = $clog2(W + 1);
  localparam int RW = $clog2(H + 1);
  typedef enum logic [1:0] {CAPTURE, HEADER, PIXELS, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;
  logic [5:0] hi, hi_n;
  logic [1:0] comp, comp_n;
  logic [23:0] even_mem [D];
  logic [23:0] odd_mem [D];
  logic [AW-1:0] addr;
  logic [23:0] pix;
  logic xfer, row_end, last_row;
  // Capture and readout share the row/col counters, hence one address.
  assign addr = AW'(row) * AW'(W / 2) + AW'(col >> 1);
  assign pix = col[0] ? odd_mem[addr] : even_mem[addr];
  assign xfer = out_valid && out_ready;
  always_ff @(posedge clk)
    if (state == CAPTURE && horizontal_Pulse) begin
      even_mem[addr] <= {data_R_Even, data_G_Even, data_B_Even};
      odd_mem[addr] <= {data_R_Odd, data_G_Odd, data_B_Odd};
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= CAPTURE;
      col <= '0;
      row <= '0;
      hi <= '0;
      comp <= '0;
    end else begin
      state <= state_n;
      col <= col_n;
      row <= row_n;
      hi <= hi_n;
      comp <= comp_n;
    end
  always_comb begin
    state_n = state;
    col_n = col;
    row_n = row;
    hi_n = hi;
    comp_n = comp;
    out_valid = state == HEADER || state == PIXELS;
    done_Flag = state == DONE;
    row_end = col == CW'(W) ? comp == 2'(LASTPAD) : comp == 2'd2 && col == CW'(W - 1) && PAD == 0;
    last_row = row == RW'(RLAST);
    out_byte = state == HEADER ? HDR[{hi, 3'b0} +: 8] :
               state == PIXELS && col != CW'(W) ? (comp == 2'd0 ? pix[7:0] : comp == 2'd1 ? pix[15:8] : pix[23:16]) :
               8'h00;
    case (state)
      CAPTURE:
        if (horizontal_Pulse) begin
          if (col == CW'(W - 2)) begin
            col_n = '0;
            if (row == RW'(H - 1)) begin
              state_n = HEADER;
              row_n = RW'(RSTART);
              hi_n = '0;
            end else row_n = row + 1'b1;
          end else col_n = col + CW'(2);
        end
      HEADER:
        if (xfer) begin
          if (hi == 6'd53) begin
            state_n = PIXELS;
            comp_n = '0;
          end else hi_n = hi + 6'd1;
        end
      PIXELS:
        if (xfer) begin
          if (row_end) begin
            col_n = '0;
            comp_n = '0;
            if (last_row) state_n = DONE;
            else row_n = DOWN ? row - 1'b1 : row + 1'b1;
          end else if (col != CW'(W) && comp == 2'd2) begin
            comp_n = '0;
            col_n = col + 1'b1;
          end else comp_n = comp + 1'b1;
        end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_write_bmp_stream.sv
// tb_write_bmp_stream: directed checks of two BMP writers (2x2 with padding, 4x1 without) sharing one pixel feed.
module tb_write_bmp_stream;
`ifdef WRITE_BMP_BOTTOM_UP_EN
  localparam bit BU = 1'b1;
`else
  localparam bit BU = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, pulse = 1'b0, ready_a = 1'b1, ready_b = 1'b0;
  logic [7:0] r_e = 0, g_e = 0, b_e = 0, r_o = 0, g_o = 0, b_o = 0;
  logic [7:0] a_byte, b_byte;
  logic a_valid, b_valid, a_done, b_done;
  int tests = 0, fails = 0, cyc = 0;
  logic [7:0] ea [70];
  logic [7:0] eb [66];
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  bit mon = 1'b0, b_st = 1'b0;
  logic [7:0] b_prev = 0;
  always #5 clk = ~clk;
  write_bmp_stream #(.IMAGE_WIDTH(2), .IMAGE_HEIGHT(2)) u_a (
    .clk(clk), .reset(reset), .horizontal_Pulse(pulse),
    .data_R_Even(r_e), .data_G_Even(g_e), .data_B_Even(b_e),
    .data_R_Odd(r_o), .data_G_Odd(g_o), .data_B_Odd(b_o),
    .out_byte(a_byte), .out_valid(a_valid), .out_ready(ready_a), .done_Flag(a_done));
  write_bmp_stream #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(1)) u_b (
    .clk(clk), .reset(reset), .horizontal_Pulse(pulse),
    .data_R_Even(r_e), .data_G_Even(g_e), .data_B_Even(b_e),
    .data_R_Odd(r_o), .data_G_Odd(g_o), .data_B_Odd(b_o),
    .out_byte(b_byte), .out_valid(b_valid), .out_ready(ready_b), .done_Flag(b_done));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    ready_b = cyc % 3 == 0;
  endtask
  // Transfers are sampled mid-cycle; a stalled byte must not change before it is taken.
  always @(negedge clk)
    if (mon && reset) begin
      if (a_valid && ready_a) qa.push_back(a_byte);
      if (b_st && b_valid) check("b_hold", b_byte, b_prev);
      if (b_valid && ready_b) qb.push_back(b_byte);
      b_st = b_valid && !ready_b;
      b_prev = b_byte;
    end
  task automatic put32(input int sel, input int i, input logic [31:0] v);
    for (int k = 0; k < 4; k++)
      if (sel == 1) eb[i + k] = v[8 * k +: 8];
      else ea[i + k] = v[8 * k +: 8];
  endtask
  task automatic fill(input logic [7:0] base);
    logic [7:0] p [12];
    p = '{8'd3, 8'd2, 8'd1, 8'd6, 8'd5, 8'd4, 8'd9, 8'd8, 8'd7, 8'd12, 8'd11, 8'd10};
    foreach (ea[i]) ea[i] = 8'h00;
    foreach (eb[i]) eb[i] = 8'h00;
    ea[0] = 8'h42; ea[1] = 8'h4D; eb[0] = 8'h42; eb[1] = 8'h4D;
    put32(0, 2, 70); put32(0, 10, 54); put32(0, 14, 40); put32(0, 18, 2);
    put32(0, 22, BU ? 32'd2 : 32'hFFFF_FFFE); ea[26] = 8'd1; ea[28] = 8'd24;
    put32(0, 34, 16); put32(0, 38, 2835); put32(0, 42, 2835);
    put32(1, 2, 66); put32(1, 10, 54); put32(1, 14, 40); put32(1, 18, 4);
    put32(1, 22, BU ? 32'd1 : 32'hFFFF_FFFF); eb[26] = 8'd1; eb[28] = 8'd24;
    put32(1, 34, 12); put32(1, 38, 2835); put32(1, 42, 2835);
    for (int k = 0; k < 12; k++) eb[54 + k] = p[k] + base;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 6; k++) ea[54 + (BU ? 1 - r : r) * 8 + k] = p[r * 6 + k] + base;
  endtask
  task automatic send(input logic [23:0] e, input logic [23:0] o);
    {r_e, g_e, b_e} = e;
    {r_o, g_o, b_o} = o;
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
  endtask
  task automatic junk();
    {r_e, g_e, b_e, r_o, g_o, b_o} = {48{1'b1}};
  endtask
  task automatic run();
    for (int k = 0; k < 600 && !(a_done && b_done); k++) tick();
    check("a_done", a_done, 1);
    check("b_done", b_done, 1);
  endtask
  task automatic compare(input string s);
    check({s, "_len_a"}, qa.size(), 70);
    check({s, "_len_b"}, qb.size(), 66);
    for (int i = 0; i < qa.size() && i < 70; i++) check($sformatf("%s_a[%0d]", s, i), qa[i], ea[i]);
    for (int i = 0; i < qb.size() && i < 66; i++) check($sformatf("%s_b[%0d]", s, i), qb[i], eb[i]);
  endtask
  task automatic restart();
    reset = 1'b0;
    tick();
    mon = 1'b0;
    qa.delete();
    qb.delete();
    b_st = 1'b0;
    reset = 1'b1;
    tick();
    mon = 1'b1;
  endtask
  initial begin
    repeat (2) tick();
    check("rst_valid", a_valid, 0);
    check("rst_done", a_done, 0);
    check("rst_byte", a_byte, 0);
    reset = 1'b1;
    tick();
    fill(8'h00);
    mon = 1'b1;
    send({8'd1, 8'd2, 8'd3}, {8'd4, 8'd5, 8'd6});
    check("cap_valid", a_valid, 0);
    junk();
    repeat (3) tick();
    check("gap_valid", a_valid, 0);
    send({8'd7, 8'd8, 8'd9}, {8'd10, 8'd11, 8'd12});
    check("hdr_valid", a_valid, 1);
    check("hdr_b_valid", b_valid, 1);
    junk();
    pulse = 1'b1;
    repeat (4) tick();
    pulse = 1'b0;
    run();
    compare("f1");
    pulse = 1'b1;
    repeat (3) begin
      tick();
      check("done_valid", a_valid, 0);
      check("done_flag", a_done, 1);
    end
    pulse = 1'b0;
    restart();
    send({8'h21, 8'h22, 8'h23}, {8'h24, 8'h25, 8'h26});
    send({8'h27, 8'h28, 8'h29}, {8'h2A, 8'h2B, 8'h2C});
    for (int k = 0; k < 200 && qa.size() < 20; k++) tick();
    check("reach_b20", qa.size(), 20);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", a_valid, 0);
    check("mid_rst_done", a_done, 0);
    check("mid_rst_byte", a_byte, 0);
    check("mid_rst_b_valid", b_valid, 0);
    restart();
    fill(8'h40);
    send({8'h41, 8'h42, 8'h43}, {8'h44, 8'h45, 8'h46});
    junk();
    tick();
    send({8'h47, 8'h48, 8'h49}, {8'h4A, 8'h4B, 8'h4C});
    run();
    compare("f3");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
